// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states,
// fault causes and the latched command record.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_FIN  = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [4:0]  rd;
  } lsu_cmd_t;

  // Stores only have SB/SH/SW; loads additionally allow LBU/LHU.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) f3_illegal = f3[2] | (f3 == 3'b011);
    else          f3_illegal = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data alignment: byte/half select from the read word and
// sign/zero extension to 32 bits.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = rdata[7:0];
    case (addr_lo)
      2'd0: sel_b = rdata[7:0];
      2'd1: sel_b = rdata[15:8];
      2'd2: sel_b = rdata[23:16];
      2'd3: sel_b = rdata[31:24];
      default: sel_b = rdata[7:0];
    endcase
    // Halfword uses addr[1] only; addr[0] is ignored when not trapped.
    sel_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{sel_b[7]}}, sel_b};
      F3_LBU:  data = {24'd0, sel_b};
      F3_LH:   data = {{16{sel_h[15]}}, sel_h};
      F3_LHU:  data = {16'd0, sel_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I multi-cycle load/store stage with single-outstanding memory bus,
// bus timeout, and optional misalignment trap (LSU_MISALIGN_TRAP_EN).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_write_enable,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state, state_nxt;
  lsu_cmd_t    cmd_q;
  logic [31:0] rdata_q, wdata_q, wdata_d, ext_data;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [15:0] cnt_q;
  logic [1:0]  cause_q, cause_d;
  logic        illegal, misalign, timeout_hit;

  // Decode of the incoming command, only meaningful while IDLE.
  always_comb begin
    illegal = f3_illegal(is_store, funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((funct3[1:0] == 2'b01) & addr[0]) |
               ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    cause_d = illegal ? CAUSE_ILLEGAL : (misalign ? CAUSE_MISALIGN : CAUSE_NONE);

    wstrb_d = 4'b0000;
    wdata_d = 32'd0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          wstrb_d = 4'b0001 << addr[1:0];
          wdata_d = {4{store_data[7:0]}};
        end
        F3_SH: begin
          wstrb_d = 4'b0011 << {addr[1], 1'b0};
          wdata_d = {2{store_data[15:0]}};
        end
        F3_SW: begin
          wstrb_d = 4'b1111;
          wdata_d = store_data;
        end
        default: begin
          wstrb_d = 4'b0000;
          wdata_d = 32'd0;
        end
      endcase
    end
  end

  assign timeout_hit = !mem_ready && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (cause_d != CAUSE_NONE) ? S_FIN : S_REQ;
      S_REQ: begin
        if (mem_ready)        state_nxt = S_RESP;
        else if (timeout_hit) state_nxt = S_FIN;
      end
      S_RESP:  state_nxt = S_IDLE;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= '0;
      rdata_q <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'b0000;
      cnt_q   <= 16'd0;
      cause_q <= CAUSE_NONE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cmd_q   <= '{is_store: is_store, funct3: funct3, addr: addr, rd: rd};
          wdata_q <= wdata_d;
          wstrb_q <= wstrb_d;
          cnt_q   <= 16'd0;
          cause_q <= cause_d;
        end
        S_REQ: begin
          if (mem_ready) rdata_q <= mem_rdata;
          else begin
            cnt_q <= cnt_q + 16'd1;
            if (timeout_hit) cause_q <= CAUSE_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  load_extend u_ext (
    .rdata   (rdata_q),
    .addr_lo (cmd_q.addr[1:0]),
    .funct3  (cmd_q.funct3),
    .data    (ext_data)
  );

  // Bus and write-back outputs are decoded from the registered state so an
  // asynchronous reset clears them immediately.
  logic load_resp;
  assign load_resp       = (state == S_RESP) && !cmd_q.is_store;
  assign mem_req         = (state == S_REQ);
  assign mem_we          = mem_req && cmd_q.is_store;
  assign mem_addr        = {cmd_q.addr[31:2], 2'b00};
  assign mem_wstrb       = mem_req ? wstrb_q : 4'b0000;
  assign mem_wdata       = wdata_q;
  assign wb_rd           = load_resp ? cmd_q.rd : 5'd0;
  assign wb_data         = load_resp ? ext_data : 32'd0;
  assign wb_write_enable = load_resp && (cmd_q.rd != 5'd0);
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_RESP) || (state == S_FIN);
  assign fault           = (state == S_FIN);
  assign fault_cause     = fault ? cause_q : CAUSE_NONE;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage of the RV32I core, sitting between execute and the register file. Accepts one load or store per command, drives a single-outstanding request/ready memory bus with byte strobes, and for loads presents the aligned, sign/zero-extended result as a one-cycle write-back to the register file (`RD`, `RD_DATA`, `WRITE_ENABLE`). A bus-timeout counter and optional misalignment trap report faults instead of hanging the core.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles `MEM_REQ` may wait for `MEM_READY` before abort; range 1..65535.
- `CLK` input 1: single clock, rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `START` input 1: command valid; sampled only when `BUSY`=0.
- `IS_STORE` input 1: 1 = store, 0 = load.
- `FUNCT3` input 3: RV32I width/sign code.
- `ADDR` input 32: byte address.
- `STORE_DATA` input 32: rs2 value.
- `RD` input 5: load destination.
- `MEM_REQ` output 1: bus request.
- `MEM_WE` output 1: 1 = write.
- `MEM_ADDR` output 32: word address, `{ADDR[31:2],2'b00}`.
- `MEM_WSTRB` output 4: byte enables (0 for loads).
- `MEM_WDATA` output 32: store data replicated into lanes.
- `MEM_READY` input 1: bus completes the access this cycle.
- `MEM_RDATA` input 32: read word, valid with `MEM_READY`.
- `WB_RD` output 5, `WB_DATA` output 32, `WB_WRITE_ENABLE` output 1: register-file write port.
- `BUSY` output 1: command in flight.
- `DONE` output 1: one-cycle pulse, command retired (success or fault).
- `FAULT` output 1: one-cycle pulse with `DONE` on error; `FAULT_CAUSE` output 2: 0 none, 1 illegal funct3, 2 misaligned, 3 bus timeout.

## Operation
- States: IDLE, REQ, RESP, FIN.
- IDLE: `START`=1 latches all command inputs, decodes, goes to REQ; on illegal funct3 (load: 011,110,111; store: 011..111) or trapped misalignment goes to FIN with fault, no bus activity.
- REQ: `MEM_REQ`=1, address/strobe/data stable; timeout counter increments each cycle `MEM_READY`=0. `MEM_READY`=1 → capture `MEM_RDATA`, go to RESP. Counter reaching `TIMEOUT_CYCLES` → drop request, FIN with cause 3.
- RESP (loads and stores): load drives `WB_WRITE_ENABLE`=1 (forced 0 if `WB_RD`=0), `WB_DATA` = extracted value; `DONE`=1; → IDLE. Store: `DONE`=1 only.
- FIN: `DONE`=1, `FAULT`=1, `FAULT_CAUSE` valid, no write-back; → IDLE.
- Load extraction: LB/LBU select byte `ADDR[1:0]`, LH/LHU select half `ADDR[1]`, sign- or zero-extend to 32; LW passes word.
- Stores: SB strobe `4'b0001<<ADDR[1:0]`, data `{4{b}}`; SH strobe `4'b0011<<{ADDR[1],1'b0}`, data `{2{h}}`; SW strobe `4'b1111`.
- `START` while `BUSY`=1 ignored.

## Timing
- Reset: state IDLE; all outputs 0; counter 0. Reset mid-access drops `MEM_REQ` immediately (asynchronously); transaction discarded, no `DONE`.
- `BUSY`=1 from cycle after accepted `START` until `DONE` cycle inclusive.
- Zero-wait load: `START` cycle 0, `MEM_REQ` cycle 1 with `MEM_READY`=1, write-back + `DONE` cycle 2; next `START` accepted cycle 3.
- Each wait cycle adds one cycle; `MEM_REQ` never drops before `MEM_READY` except on timeout/reset.
- Timeout: `MEM_REQ` high exactly `TIMEOUT_CYCLES` cycles, then FIN next cycle.
- Decode faults: `DONE`/`FAULT` cycle 1.
- `MEM_READY` outside REQ ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: halfword with `ADDR[0]`=1 or word with `ADDR[1:0]`≠0 → cause 2, no bus access.
- Not defined: misaligned accesses proceed; offending low address bits are ignored (half uses `ADDR[1]`, word uses aligned word); cause 2 never reported.

## Structure
- Package `lsu_pkg`: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), state enum, fault-cause constants.
- Sub-module `load_extend`: combinational byte/half select and sign/zero extension from `MEM_RDATA`, `ADDR[1:0]`, `FUNCT3`.

## Test plan
- LBU addr 0x103, `MEM_RDATA`=0x80112233, zero-wait, `RD`=5 → cycle 2 `WB_DATA`=0x00000080, `WB_RD`=5, `WB_WRITE_ENABLE`=1.
- LH addr 0x102, `MEM_RDATA`=0x8001FFFF, 3 wait cycles → `WB_DATA`=0xFFFF8001 at cycle 5, `DONE` same cycle.
- SB addr 0x201, `STORE_DATA`=0x000000AB → `MEM_WSTRB`=0010, `MEM_WDATA`=0xABABABAB, `MEM_ADDR`=0x200, no write-back.
- `TIMEOUT_CYCLES`=4, `MEM_READY` held 0 → `MEM_REQ` high 4 cycles, then `DONE`=`FAULT`=1, cause 3.
- With macro: LW addr 0x102 → cycle 1 cause 2, `MEM_REQ` never asserted; without: access to 0x100 completes normally.
- LW to `RD`=0 and `START` during `BUSY` → no write enable; second command ignored; reset in REQ clears `MEM_REQ`/`BUSY` immediately.
